// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the four-digit seven-segment scanner.
//   PWM_W      - width of the brightness/PWM subslot counter
//   NUM_DIGITS - number of multiplexed digits
//   BLANK_CODE - register-file code that turns a digit fully off
//   HEX_TAB    - active-low {dp,g,f,e,d,c,b,a} patterns for hex 0..F, dp off
package seg_pkg;

   localparam int PWM_W      = 3;
   localparam int NUM_DIGITS = 4;

   localparam logic [5:0] BLANK_CODE = 6'b100000;

   // Index 0 is the rightmost entry, so HEX_TAB[h] is the pattern for h.
   localparam logic [15:0][7:0] HEX_TAB = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational code-to-segment decoder.
//   code : in  6  {blank, dp, hex[3:0]}
//   pat  : out 8  active-low {dp,g,f,e,d,c,b,a}
module seg_decode
   import seg_pkg::*;
(
   input  logic [5:0] code,
   output logic [7:0] pat
);

   always_comb begin
      pat = 8'hFF;
      if (!code[5])
         pat = {~code[4], HEX_TAB[code[3:0]][6:0]};
   end

endmodule

// File: rtl/seg_scan_4.sv
// seg_scan_4: four-digit multiplexed seven-segment driver with PWM brightness.
//   clk        : in  1  system clock, rising edge
//   rst        : in  1  synchronous active-high reset
//   wr_en      : in  1  register-file write strobe
//   wr_addr    : in  2  digit index to write
//   wr_data    : in  6  {blank, dp, hex[3:0]}
//   bright     : in  3  brightness 0..7 (0 = 1/8 duty, 7 = full)
//   digit_sel  : out 4  active-low one-cold digit strobe
//   seg        : out 8  active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick : out 1  one-cycle pulse at the start of each new frame
module seg_scan_4
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 2499
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [5:0] wr_data,
   input  logic [2:0] bright,
   output logic [3:0] digit_sel,
   output logic [7:0] seg,
   output logic       frame_tick
);

   localparam int PRE_W = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(SCAN_DIV);

   logic [PRE_W-1:0]                 pre;
   logic [PWM_W-1:0]                 pwm;
   logic [1:0]                       cur;
   logic [NUM_DIGITS-1:0][5:0]       ent;
   logic                             tc;
   logic                             wrap;
   logic                             wrap_q;
   logic [7:0]                       dec_pat;

   assign tc   = (pre == PRE_TC);
   // Last terminal count of the last PWM subslot of the last digit.
   assign wrap = tc && (pwm == '1) && (cur == 2'd3);

   // Scan counters: prescaler -> PWM subslot -> digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         pwm <= '0;
         cur <= '0;
      end else if (tc) begin
         pre <= '0;
         pwm <= pwm + PWM_W'(1);
         if (pwm == '1)
            cur <= cur + 2'd1;
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

   // Register file; reset has priority so a write in the reset cycle is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            ent[i] <= BLANK_CODE;
      end else if (wr_en) begin
         ent[wr_addr] <= wr_data;
      end
   end

   seg_decode u_dec (
      .code (ent[cur]),
      .pat  (dec_pat)
   );

   // Outputs are registered from the current scan state, so they trail the
   // counters by one cycle; the frame tick is delayed one more so it lands on
   // the first strobe of digit 0 rather than on the counter wrap itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_sel  <= 4'b1111;
         seg        <= 8'hFF;
         wrap_q     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         digit_sel  <= (pwm <= bright) ? ~(4'd1 << cur) : 4'b1111;
         seg        <= dec_pat;
         wrap_q     <= wrap;
         frame_tick <= wrap_q;
      end
   end

endmodule

// File: tb/tb_seg_scan_4.sv
module tb_seg_scan_4;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [5:0] wr_data;
   logic [2:0] bright;
   logic [3:0] digit_sel;
   logic [7:0] seg;
   logic       frame_tick;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   seg_scan_4 #(.SCAN_DIV(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .bright     (bright),
      .digit_sel  (digit_sel),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0] addr;
      logic [5:0] data;
      logic [7:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // one rising edge, then land on the falling edge for sampling/driving
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wr(input logic [1:0] a, input logic [5:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_dig(input logic [1:0] d, output bit ok);
      logic [3:0] want;
      want = ~(4'd1 << d);
      ok = 0;
      step();
      for (int i = 0; i < 200 && !ok; i++) begin
         if (digit_sel == want) ok = 1;
         else step();
      end
   endtask

   vec_t vt[18];
   int   bl[3];
   int   on_exp[3];
   int   off_exp[3];

   initial begin
      bit ok;
      int cnt[4];
      int off;
      int errs[4];
      int t0;
      logic [3:0] ds;

      vt[0]  = '{2'd0, 6'h00, 8'hC0};
      vt[1]  = '{2'd0, 6'h01, 8'hF9};
      vt[2]  = '{2'd0, 6'h02, 8'hA4};
      vt[3]  = '{2'd0, 6'h03, 8'hB0};
      vt[4]  = '{2'd0, 6'h04, 8'h99};
      vt[5]  = '{2'd0, 6'h05, 8'h92};
      vt[6]  = '{2'd0, 6'h06, 8'h82};
      vt[7]  = '{2'd0, 6'h07, 8'hF8};
      vt[8]  = '{2'd0, 6'h08, 8'h80};
      vt[9]  = '{2'd0, 6'h09, 8'h90};
      vt[10] = '{2'd0, 6'h0A, 8'h88};
      vt[11] = '{2'd0, 6'h0B, 8'h83};
      vt[12] = '{2'd0, 6'h0C, 8'hC6};
      vt[13] = '{2'd0, 6'h0D, 8'hA1};
      vt[14] = '{2'd0, 6'h0E, 8'h86};
      vt[15] = '{2'd0, 6'h0F, 8'h8E};
      vt[16] = '{2'd3, 6'h11, 8'h79};
      vt[17] = '{2'd3, 6'h2F, 8'hFF};
      bl      = '{7, 0, 3};
      on_exp  = '{32, 4, 16};
      off_exp = '{0, 112, 64};

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; bright = 3'd7;

      // reset held two cycles, with a write that must be ignored
      step();
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 6'h08;
      step();
      wr_en = 1'b0;
      chk("rst_dsel", digit_sel, 4'b1111);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_tick", frame_tick, 1'b0);
      rst = 1'b0;
      step();
      chk("rel_dsel", digit_sel, 4'b1110);
      chk("rel_seg", seg, 8'hFF);
      repeat (31) step();
      chk("rot_d0_end", digit_sel, 4'b1110);
      step();
      chk("rot_d1", digit_sel, 4'b1101);
      repeat (32) step();
      chk("rot_d2", digit_sel, 4'b1011);
      repeat (32) step();
      chk("rot_d3", digit_sel, 4'b0111);
      chk("rot_seg_blank", seg, 8'hFF);

      // hex write on digit 1; others stay blank
      wr(2'd1, 6'h05);
      step();
      errs = '{0, 0, 0, 0};
      for (int c = 0; c < 128; c++) begin
         for (int d = 0; d < 4; d++) begin
            ds = ~(4'd1 << d);
            if (digit_sel == ds && seg !== ((d == 1) ? 8'h92 : 8'hFF)) errs[d]++;
         end
         step();
      end
      for (int d = 0; d < 4; d++) chk($sformatf("hex_win_d%0d_errs", d), errs[d], 0);

      // decimal point then blank on digit 2
      wr(2'd2, 6'h18);
      wait_dig(2'd2, ok);
      chk("dp_wait", ok, 1);
      chk("dp_seg", seg, 8'h00);
      wr(2'd2, 6'h38);
      wait_dig(2'd2, ok);
      chk("blank_wait", ok, 1);
      chk("blank_seg", seg, 8'hFF);

      // back-to-back writes: last one wins
      wr(2'd2, 6'h01);
      wr(2'd2, 6'h0C);
      wait_dig(2'd2, ok);
      chk("b2b_seg", seg, 8'hC6);

      // decode table
      for (int i = 0; i < 18; i++) begin
         wr(vt[i].addr, vt[i].data);
         wait_dig(vt[i].addr, ok);
         chk($sformatf("dec%0d_wait", i), ok, 1);
         chk($sformatf("dec%0d_seg", i), seg, vt[i].exp);
      end

      // brightness duty over one full frame
      for (int b = 0; b < 3; b++) begin
         bright = 3'(bl[b]);
         step(); step();
         cnt = '{0, 0, 0, 0}; off = 0;
         for (int c = 0; c < 128; c++) begin
            if (digit_sel == 4'b1111) off++;
            for (int d = 0; d < 4; d++) begin
               ds = ~(4'd1 << d);
               if (digit_sel == ds) cnt[d]++;
            end
            step();
         end
         for (int d = 0; d < 4; d++)
            chk($sformatf("br%0d_d%0d_on", bl[b], d), cnt[d], on_exp[b]);
         chk($sformatf("br%0d_off", bl[b]), off, off_exp[b]);
      end
      bright = 3'd7;

      // frame tick spacing and alignment
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step();
         if (frame_tick) ok = 1;
      end
      chk("tick1_seen", ok, 1);
      chk("tick1_dsel", digit_sel, 4'b1110);
      t0 = cyc;
      step();
      chk("tick_one_cycle", frame_tick, 1'b0);
      chk("tick_after_dsel", digit_sel, 4'b1110);
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step();
         if (frame_tick) ok = 1;
      end
      chk("tick2_seen", ok, 1);
      chk("tick_period", cyc - t0, 128);

      // mid-frame reset with a concurrent write
      wr(2'd0, 6'h01); wr(2'd1, 6'h02); wr(2'd2, 6'h03); wr(2'd3, 6'h04);
      wait_dig(2'd2, ok);
      chk("mid_wait", ok, 1);
      chk("mid_pre_seg", seg, 8'hB0);
      rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 6'h07;
      step();
      rst = 1'b0; wr_en = 1'b0;
      chk("mid_rst_dsel", digit_sel, 4'b1111);
      chk("mid_rst_seg", seg, 8'hFF);
      chk("mid_rst_tick", frame_tick, 1'b0);
      step();
      chk("mid_rel_dsel", digit_sel, 4'b1110);
      errs = '{0, 0, 0, 0};
      for (int c = 0; c < 130; c++) begin
         if (seg !== 8'hFF) errs[0]++;
         step();
      end
      chk("mid_all_blank_errs", errs[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
